reg_disp_scan: RTL and testbench

Downstream consumer of the single-cycle computer's register debug port: drives reg_sel, reads reg_data, and shows the selected 32-bit register as 8 hex digits on a multiplexed common-anode 7-segment display. It auto-steps through the register file, or holds and steps manually, so board users can inspect CPU state. Sits beside the CPU core in the board top level, fed by the same clock.

---
 rtl/reg_disp_pkg.sv | 17 +
 rtl/hex7seg.sv | 13 +
 rtl/reg_disp_scan.sv | 115 +++++++++++
 tb/tb_reg_disp_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_disp_pkg.sv
// reg_disp_pkg: shared constants for the register display scanner.
//   NUM_DIGITS  - hex digits per displayed register
//   SEG_BLANK   - active-low segment pattern with every segment off
//   AN_OFF      - active-low anode pattern with every digit off
//   HEX7_TABLE  - nibble -> active-low {g,f,e,d,c,b,a}
package reg_disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to 7-segment decoder.
//   nib_i [3:0] : hex digit value
//   seg_o [6:0] : active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import reg_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/reg_disp_scan.sv
// reg_disp_scan: scans the CPU register file through its debug port and shows
// the selected 32-bit register as 8 hex digits on a multiplexed common-anode
// 7-segment display.
//   clk      in   system clock (shared with the CPU)
//   rst      in   asynchronous active-high reset
//   pause    in   level, hold the current register
//   step     in   one-cycle pulse, advance to the next register
//   reg_sel  out  register index to the CPU debug port
//   reg_data in   register value for reg_sel (combinational from the CPU)
//   an       out  active-low digit enables, an[i] = digit i
//   seg      out  active-low segments {dp,g,f,e,d,c,b,a}
// Build option: define REG_DISP_LEADZ_EN for leading-zero blanking.
module reg_disp_scan
  import reg_disp_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int DWELL    = 100,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        step,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic       tick;
  logic       frame_end;
  logic       adv;
  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic       lz_blank;

  assign tick      = (presc_q == PW'(CLK_DIV - 1));
  assign frame_end = tick && (digit_q == 3'd7);
  // step always advances; a coincident auto-advance merges into the same +1
  assign adv       = step || (frame_end && !pause && (frame_q == FW'(DWELL - 1)));
  assign nib       = shadow_q[{digit_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

`ifdef REG_DISP_LEADZ_EN
  // digit 0 is never blanked so a zero value still shows a single "0"
  assign lz_blank = (digit_q != 3'd0) && ((shadow_q >> {digit_q, 2'b00}) == 32'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    digit_d  = tick ? digit_q + 3'd1 : digit_q;
    // reload only at the frame wrap so each frame shows one coherent value
    shadow_d = frame_end ? reg_data : shadow_q;
    sel_d    = sel_q;
    frame_d  = frame_q;
    an_d     = an_q;
    seg_d    = seg_q;

    if (adv) begin
      sel_d   = (sel_q == 5'(NUM_REGS - 1)) ? 5'd0 : sel_q + 5'd1;
      frame_d = '0;
    end else if (frame_end && !pause) begin
      frame_d = frame_q + 1'b1;
    end

    // outputs latch the digit being left on each tick; they stay at the
    // reset blank pattern until the first tick arrives
    if (tick) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = lz_blank ? SEG_BLANK : {1'b1, hex_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      digit_q  <= 3'd0;
      frame_q  <= '0;
      sel_q    <= 5'd0;
      shadow_q <= 32'd0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign reg_sel = sel_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_reg_disp_scan.sv
// tb_reg_disp_scan: bench for reg_disp_scan with CLK_DIV=4, DWELL=2,
// NUM_REGS=32 and a CPU stand-in returning 32'h1000_0000 + reg_sel.
// Honours REG_DISP_LEADZ_EN for the leading-zero expectations.
module tb_reg_disp_scan;

  localparam int CLK_DIV  = 4;
  localparam int DWELL    = 2;
  localparam int NUM_REGS = 32;
  localparam int FRAME    = 8 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        ovr = 1'b0;
  logic [31:0] ovr_val = 32'd0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  an;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign reg_data = ovr ? ovr_val : 32'h1000_0000 + {27'd0, reg_sel};

  reg_disp_scan #(
    .CLK_DIV  (CLK_DIV),
    .DWELL    (DWELL),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pause    (pause),
    .step     (step),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .an       (an),
    .seg      (seg)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] disp_seg(input logic [31:0] v, input int d);
    logic [3:0] n;
    n = v[4*d +: 4];
`ifdef REG_DISP_LEADZ_EN
    if (d > 0 && (v >> (4 * d)) == 32'd0) return 8'hFF;
`endif
    return {1'b1, hex7(n)};
  endfunction

  // model: edges counted since reset release; every CLK_DIV-th edge is a
  // digit tick, every 8th tick is a frame wrap
  int          m_k;
  int          m_frames;
  int          m_t;
  int          m_d;
  logic        m_adv;
  logic [4:0]  m_sel;
  logic [31:0] m_shadow;
  logic [7:0]  exp_an;
  logic [7:0]  exp_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k      = 0;
      m_frames = 0;
      m_sel    = 5'd0;
      m_shadow = 32'd0;
      exp_an   = 8'hFF;
      exp_seg  = 8'hFF;
    end else begin
      m_k++;
      m_adv = step;
      if (m_k % CLK_DIV == 0) begin
        m_t     = m_k / CLK_DIV;
        m_d     = (m_t - 1) % 8;
        exp_an  = ~(8'b1 << m_d);
        exp_seg = disp_seg(m_shadow, m_d);
        if (m_d == 7) begin
          m_shadow = ovr ? ovr_val : 32'h1000_0000 + 32'(m_sel);
          if (!pause) begin
            m_frames++;
            if (m_frames == DWELL) m_adv = 1'b1;
          end
        end
      end
      if (m_adv) begin
        m_sel    = 5'((int'(m_sel) + 1) % NUM_REGS);
        m_frames = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, m_k, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_an", {24'd0, an}, {24'd0, exp_an});
      chk("model_seg", {24'd0, seg}, {24'd0, exp_seg});
      chk("model_reg_sel", {27'd0, reg_sel}, {27'd0, m_sel});
    end
  end

  task automatic goto(input int n);
    while (m_k < n) @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  int  b;
  bit  found;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", {24'd0, an}, 32'hFF);
    chk("reset_seg", {24'd0, seg}, 32'hFF);
    chk("reset_sel", {27'd0, reg_sel}, 32'd0);
    rst = 1'b0;

    // blank until first tick, then one digit per CLK_DIV cycles
    goto(3);   chk("pre_tick_an", {24'd0, an}, 32'hFF);
    goto(4);   chk("tick1_an", {24'd0, an}, 32'hFE);
               chk("tick1_seg", {24'd0, seg}, 32'hC0);
    goto(8);   chk("tick2_an", {24'd0, an}, 32'hFD);
    goto(32);  chk("frame1_d7_an", {24'd0, an}, 32'h7F);
               chk("frame1_d7_seg", {24'd0, seg}, 32'hC0);
    goto(36);  chk("frame2_d0_seg", {24'd0, seg}, 32'hC0);
    goto(60);  chk("frame2_d6_an", {24'd0, an}, 32'hBF);
               chk("frame2_d6_seg", {24'd0, seg}, 32'hC0);
    goto(64);  chk("frame2_d7_seg", {24'd0, seg}, 32'hF9);
               chk("auto_adv_sel", {27'd0, reg_sel}, 32'd1);
    goto(68);  chk("frame3_d0_seg", {24'd0, seg}, 32'hC0);
    goto(100); chk("frame4_d0_an", {24'd0, an}, 32'hFE);
               chk("frame4_d0_seg", {24'd0, seg}, 32'hF9);

    // step up to the last register, then let auto-advance wrap
    repeat (30) pulse_step();
    chk("step_to_31", {27'd0, reg_sel}, 32'd31);
    for (int i = 0; i < 200 && reg_sel == 5'd31; i++) @(negedge clk);
    chk("wrap_to_0", {27'd0, reg_sel}, 32'd0);

    // pause holds the register; step still advances once
    pause = 1'b1;
    repeat (10 * FRAME) @(negedge clk);
    chk("pause_hold", {27'd0, reg_sel}, 32'd0);
    pulse_step();
    chk("pause_step", {27'd0, reg_sel}, 32'd1);
    repeat (2 * FRAME) @(negedge clk);
    chk("pause_step_once", {27'd0, reg_sel}, 32'd1);
    pause = 1'b0;

    // step coincident with an auto-advance frame wrap
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (((m_k + 1) % FRAME == 0) && m_frames == DWELL - 1) begin
        pulse_step();
        chk("coincident_step", {27'd0, reg_sel}, 32'd2);
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) chk("coincident_window_found", 32'd0, 32'd1);

    // small value: leading-zero behaviour depends on build option
    ovr_val = 32'h0000_00AF;
    ovr = 1'b1;
    b = ((m_k / FRAME) + 1) * FRAME;
    goto(b + 4);  chk("af_d0_seg", {24'd0, seg}, 32'h8E);
    goto(b + 8);  chk("af_d1_seg", {24'd0, seg}, 32'h88);
    goto(b + 12); chk("af_d2_an", {24'd0, an}, 32'hFB);
`ifdef REG_DISP_LEADZ_EN
                  chk("af_d2_seg", {24'd0, seg}, 32'hFF);
`else
                  chk("af_d2_seg", {24'd0, seg}, 32'hC0);
`endif

    // asynchronous reset mid-frame
    goto(b + 14);
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", {24'd0, an}, 32'hFF);
    chk("midrst_seg", {24'd0, seg}, 32'hFF);
    chk("midrst_sel", {27'd0, reg_sel}, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
